// File: rtl/rvfi_serializer_pkg.sv
// Shared field widths and packed-entry layout for the RVFI retire serializer.
// An entry is {chan, trap, order, insn, pre_pc, post_pc} from MSB to LSB.
package rvfi_serializer_pkg;

    localparam int ORDER_W = 8;
    localparam int INSN_W  = 32;
    localparam int CHAN_W  = 2;

    function automatic int entry_w(input int xlen);
        return CHAN_W + 1 + ORDER_W + INSN_W + 2 * xlen;
    endfunction

    function automatic int off_post_pc(input int xlen);
        return 0 * xlen;
    endfunction

    function automatic int off_pre_pc(input int xlen);
        return xlen;
    endfunction

    function automatic int off_insn(input int xlen);
        return 2 * xlen;
    endfunction

    function automatic int off_order(input int xlen);
        return 2 * xlen + INSN_W;
    endfunction

    function automatic int off_trap(input int xlen);
        return 2 * xlen + INSN_W + ORDER_W;
    endfunction

    function automatic int off_chan(input int xlen);
        return 2 * xlen + INSN_W + ORDER_W + 1;
    endfunction

endpackage

// File: rtl/rvfi_serializer_mem.sv
// Entry storage: NRET write ports landing on consecutive slots from a base
// pointer, plus one asynchronous read port for the FIFO head.
module rvfi_serializer_mem #(
    parameter int NRET  = 2,
    parameter int DEPTH = 8,
    parameter int EW    = 107
) (
    input  logic                     i_clk,
    input  logic [NRET-1:0]          i_we,
    input  logic [$clog2(DEPTH)-1:0] i_base,
    input  logic [NRET*EW-1:0]       i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [EW-1:0]            o_rdata
);
    localparam int AW = $clog2(DEPTH);

    logic [EW-1:0] r_mem [DEPTH];

    // Slots never collide: DEPTH >= NRET and the address wraps modulo DEPTH.
    always_ff @(posedge i_clk) begin
        for (int j = 0; j < NRET; j++) begin
            if (i_we[j]) begin
                r_mem[i_base + AW'(j)] <= i_wdata[j*EW +: EW];
            end
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/rvfi_retire_serializer.sv
// Serializes NRET RVFI retirement channels into one in-order stream through a
// small FIFO, flagging dropped groups and order-number discontinuities.
module rvfi_retire_serializer
    import rvfi_serializer_pkg::*;
#(
    parameter int NRET  = 2,
    parameter int XLEN  = 32,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NRET-1:0]            in_valid,
    input  logic [NRET*ORDER_W-1:0]    in_order,
    input  logic [NRET*INSN_W-1:0]     in_insn,
    input  logic [NRET*XLEN-1:0]       in_pre_pc,
    input  logic [NRET*XLEN-1:0]       in_post_pc,
    input  logic [NRET-1:0]            in_trap,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CHAN_W-1:0]          out_chan,
    output logic [ORDER_W-1:0]         out_order,
    output logic [INSN_W-1:0]          out_insn,
    output logic [XLEN-1:0]            out_pre_pc,
    output logic [XLEN-1:0]            out_post_pc,
    output logic                       out_trap,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       order_err
);
    localparam int AW      = $clog2(DEPTH);
    localparam int CW      = AW + 1;
    localparam int EW      = entry_w(XLEN);
    localparam int O_POST  = off_post_pc(XLEN);
    localparam int O_PRE   = off_pre_pc(XLEN);
    localparam int O_INSN  = off_insn(XLEN);
    localparam int O_ORDER = off_order(XLEN);
    localparam int O_TRAP  = off_trap(XLEN);
    localparam int O_CHAN  = off_chan(XLEN);

    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_count;
    logic               r_overflow;
    logic               r_order_err;
    logic [ORDER_W-1:0] r_exp_order;
    logic               r_exp_vld;

    logic [EW-1:0]      w_ent [NRET];
    logic [NRET*EW-1:0] w_wdata;
    logic [NRET-1:0]    w_slot_we;
    logic [CW-1:0]      w_n;
    logic               w_chain_err;
    logic [ORDER_W-1:0] w_exp_nxt;
    logic               w_pop;
    logic               w_accept;
    logic [EW-1:0]      w_rdata;

    for (genvar k = 0; k < NRET; k++) begin : g_pack
        assign w_ent[k] = {CHAN_W'(k), in_trap[k],
                           in_order[k*ORDER_W +: ORDER_W],
                           in_insn[k*INSN_W +: INSN_W],
                           in_pre_pc[k*XLEN +: XLEN],
                           in_post_pc[k*XLEN +: XLEN]};
    end

    // Compact valid channels into the low slots, then walk them in slot order
    // chaining the expected order number from one entry to the next.
    always_comb begin
        int                 v_cnt;
        logic [ORDER_W-1:0] v_exp;
        logic               v_vld;
        logic [ORDER_W-1:0] v_ord;
        w_wdata     = '0;
        w_slot_we   = '0;
        w_chain_err = 1'b0;
        v_cnt       = 0;
        v_exp       = r_exp_order;
        v_vld       = r_exp_vld;
        v_ord       = '0;
        for (int k = 0; k < NRET; k++) begin
            if (in_valid[k]) begin
                w_wdata[v_cnt*EW +: EW] = w_ent[k];
                v_cnt = v_cnt + 1;
            end
        end
        for (int j = 0; j < NRET; j++) begin
            w_slot_we[j] = (j < v_cnt);
            if (j < v_cnt) begin
                v_ord = w_wdata[j*EW + O_ORDER +: ORDER_W];
                if (v_vld && (v_ord != v_exp)) begin
                    w_chain_err = 1'b1;
                end
                v_exp = v_ord + 8'd1;
                v_vld = 1'b1;
            end
        end
        w_n       = CW'(v_cnt);
        w_exp_nxt = v_exp;
    end

    // Handshake: the head transfers on any edge where out_valid && out_ready;
    // out_ready while empty is ignored, and the head holds until it transfers.
    assign w_pop    = (r_count != '0) && out_ready;
    assign w_accept = (w_n != '0) &&
                      ((int'(r_count) - int'(w_pop) + int'(w_n)) <= DEPTH);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_order_err <= 1'b0;
            r_exp_order <= '0;
            r_exp_vld   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wr_ptr    <= r_wr_ptr + w_n[AW-1:0];
                r_exp_order <= w_exp_nxt;
                r_exp_vld   <= 1'b1;
                r_order_err <= r_order_err | w_chain_err;
            end else if (w_n != '0) begin
                r_overflow  <= 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + (w_accept ? w_n : '0) - CW'(w_pop);
        end
    end

    rvfi_serializer_mem #(
        .NRET  (NRET),
        .DEPTH (DEPTH),
        .EW    (EW)
    ) u_mem (
        .i_clk   (clk),
        .i_we    (w_slot_we & {NRET{w_accept}}),
        .i_base  (r_wr_ptr),
        .i_wdata (w_wdata),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    assign out_valid   = (r_count != '0);
    assign out_chan    = out_valid ? w_rdata[O_CHAN +: CHAN_W]   : '0;
    assign out_trap    = out_valid ? w_rdata[O_TRAP]             : 1'b0;
    assign out_order   = out_valid ? w_rdata[O_ORDER +: ORDER_W] : '0;
    assign out_insn    = out_valid ? w_rdata[O_INSN +: INSN_W]   : '0;
    assign out_pre_pc  = out_valid ? w_rdata[O_PRE +: XLEN]      : '0;
    assign out_post_pc = out_valid ? w_rdata[O_POST +: XLEN]     : '0;
    assign count       = r_count;
    assign overflow    = r_overflow;
    assign order_err   = r_order_err;

endmodule

// File: tb/tb_rvfi_retire_serializer.sv
// Directed bench for rvfi_retire_serializer: a queue-based reference model
// checked every cycle, plus literal expectations for the key scenarios.
module tb_rvfi_retire_serializer;
    localparam int NRET  = 2;
    localparam int XLEN  = 32;
    localparam int DEPTH = 8;

    typedef struct {
        logic [1:0]  chan;
        logic        trap;
        logic [7:0]  order;
        logic [31:0] insn;
        logic [31:0] pre;
        logic [31:0] post;
    } ent_t;

    logic                   clk = 1'b0;
    logic                   reset = 1'b0;
    logic [NRET-1:0]        in_valid = '0;
    logic [NRET*8-1:0]      in_order = '0;
    logic [NRET*32-1:0]     in_insn = '0;
    logic [NRET*XLEN-1:0]   in_pre_pc = '0;
    logic [NRET*XLEN-1:0]   in_post_pc = '0;
    logic [NRET-1:0]        in_trap = '0;
    logic                   out_ready = 1'b0;
    logic                   out_valid;
    logic [1:0]             out_chan;
    logic [7:0]             out_order;
    logic [31:0]            out_insn;
    logic [XLEN-1:0]        out_pre_pc;
    logic [XLEN-1:0]        out_post_pc;
    logic                   out_trap;
    logic [$clog2(DEPTH):0] count;
    logic                   overflow;
    logic                   order_err;

    int total = 0;
    int bad   = 0;
    bit done  = 1'b0;

    ent_t       mq[$];
    logic       m_overflow = 1'b0;
    logic       m_order_err = 1'b0;
    logic [7:0] m_exp = '0;
    logic       m_exp_vld = 1'b0;

    rvfi_retire_serializer #(.NRET(NRET), .XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_order(in_order),
        .in_insn(in_insn), .in_pre_pc(in_pre_pc), .in_post_pc(in_post_pc),
        .in_trap(in_trap), .out_valid(out_valid), .out_ready(out_ready),
        .out_chan(out_chan), .out_order(out_order), .out_insn(out_insn),
        .out_pre_pc(out_pre_pc), .out_post_pc(out_post_pc), .out_trap(out_trap),
        .count(count), .overflow(overflow), .order_err(order_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic ent_t mk(input int k, input logic [7:0] o);
        ent_t e;
        e.chan  = 2'(k);
        e.order = o;
        e.pre   = 32'h1000 * k + {22'd0, o, 2'b00};
        e.post  = e.pre + 32'd4;
        e.insn  = {16'h0, o, 8'h13};
        e.trap  = o[2] ^ k[0];
        return e;
    endfunction

    // Reference model: a queue of whole entries, pop first, then all-or-nothing push.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            m_overflow  = 1'b0;
            m_order_err = 1'b0;
            m_exp       = '0;
            m_exp_vld   = 1'b0;
        end else begin
            int n;
            n = $countones(in_valid);
            if (mq.size() != 0 && out_ready) void'(mq.pop_front());
            if (n > 0) begin
                if (mq.size() + n <= DEPTH) begin
                    for (int k = 0; k < NRET; k++) begin
                        if (in_valid[k]) begin
                            ent_t e;
                            e = mk(k, in_order[k*8 +: 8]);
                            mq.push_back(e);
                            if (m_exp_vld && e.order != m_exp) m_order_err = 1'b1;
                            m_exp     = e.order + 8'd1;
                            m_exp_vld = 1'b1;
                        end
                    end
                end else begin
                    m_overflow = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!done) begin
            chk("count", 64'(count), 64'(mq.size()));
            chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
            chk("overflow", 64'(overflow), 64'(m_overflow));
            chk("order_err", 64'(order_err), 64'(m_order_err));
            if (mq.size() != 0) begin
                chk("head_chan", 64'(out_chan), 64'(mq[0].chan));
                chk("head_order", 64'(out_order), 64'(mq[0].order));
                chk("head_insn", 64'(out_insn), 64'(mq[0].insn));
                chk("head_pre", 64'(out_pre_pc), 64'(mq[0].pre));
                chk("head_post", 64'(out_post_pc), 64'(mq[0].post));
                chk("head_trap", 64'(out_trap), 64'(mq[0].trap));
            end else begin
                chk("idle_fields", {out_chan, out_trap, out_order, out_insn},
                    64'd0);
                chk("idle_pcs", {out_pre_pc, out_post_pc}, 64'd0);
            end
        end
    end

    task automatic step(input logic [1:0] v, input logic [7:0] o0,
                        input logic [7:0] o1, input logic rdy);
        ent_t e0, e1;
        e0 = mk(0, o0);
        e1 = mk(1, o1);
        in_valid   = v;
        in_order   = {e1.order, e0.order};
        in_insn    = {e1.insn, e0.insn};
        in_pre_pc  = {e1.pre, e0.pre};
        in_post_pc = {e1.post, e0.post};
        in_trap    = {e1.trap, e0.trap};
        out_ready  = rdy;
        @(posedge clk);
        #1;
        in_valid  = '0;
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        logic [7:0] ord;
        logic [1:0] vv [10];
        vv = '{2'b01, 2'b11, 2'b10, 2'b11, 2'b11, 2'b00, 2'b11, 2'b11, 2'b01, 2'b11};

        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_flags", {overflow, order_err}, 64'd0);
        chk("rst_fields", {out_order, out_post_pc}, 64'd0);
        reset = 1'b0;

        // single retirement on ch0
        step(2'b01, 8'd0, 8'd0, 1'b0);
        chk("t1_valid", 64'(out_valid), 64'd1);
        chk("t1_chan", 64'(out_chan), 64'd0);
        chk("t1_order", 64'(out_order), 64'd0);
        chk("t1_post", 64'(out_post_pc), 64'h4);
        chk("t1_count", 64'(count), 64'd1);
        step(2'b00, 8'd0, 8'd0, 1'b1);
        chk("t1_drain", 64'(count), 64'd0);

        // dual-channel group
        do_reset();
        step(2'b11, 8'd5, 8'd6, 1'b0);
        chk("t2_count", 64'(count), 64'd2);
        chk("t2_head", {out_chan, out_order}, {2'd0, 8'd5});
        step(2'b00, 8'd0, 8'd0, 1'b1);
        chk("t2_second", {out_chan, out_order}, {2'd1, 8'd6});
        step(2'b00, 8'd0, 8'd0, 1'b1);
        chk("t2_empty", 64'(out_valid), 64'd0);
        chk("t2_err", 64'(order_err), 64'd0);

        // overflow and simultaneous pop at the capacity limit
        do_reset();
        step(2'b11, 8'd10, 8'd11, 1'b0);
        step(2'b11, 8'd12, 8'd13, 1'b0);
        step(2'b11, 8'd14, 8'd15, 1'b0);
        step(2'b11, 8'd16, 8'd17, 1'b0);
        chk("t3_full", 64'(count), 64'd8);
        step(2'b11, 8'd18, 8'd19, 1'b0);
        chk("t3_drop_count", 64'(count), 64'd8);
        chk("t3_overflow", 64'(overflow), 64'd1);
        step(2'b00, 8'd0, 8'd0, 1'b1);
        chk("t3_seven", 64'(count), 64'd7);
        step(2'b01, 8'd18, 8'd0, 1'b1);
        chk("t3_pop_push", 64'(count), 64'd7);
        chk("t3_head", 64'(out_order), 64'd12);
        chk("t3_tracker", 64'(order_err), 64'd0);
        step(2'b11, 8'd19, 8'd20, 1'b1);
        chk("t3_refill", 64'(count), 64'd8);
        repeat (8) step(2'b00, 8'd0, 8'd0, 1'b1);
        chk("t3_drained", 64'(count), 64'd0);
        chk("t3_sticky", 64'(overflow), 64'd1);

        // order wrap, then a discontinuity
        do_reset();
        step(2'b01, 8'd254, 8'd0, 1'b1);
        step(2'b10, 8'd0, 8'd255, 1'b1);
        step(2'b01, 8'd0, 8'd0, 1'b1);
        chk("t4_wrap_ok", 64'(order_err), 64'd0);
        do_reset();
        step(2'b01, 8'd3, 8'd0, 1'b1);
        step(2'b01, 8'd5, 8'd0, 1'b1);
        chk("t4_gap", 64'(order_err), 64'd1);
        step(2'b11, 8'd6, 8'd7, 1'b1);
        chk("t4_sticky", 64'(order_err), 64'd1);

        // ch1-only retirement, then asynchronous reset with entries buffered
        do_reset();
        step(2'b10, 8'd0, 8'd9, 1'b0);
        chk("t5_chan", {out_chan, out_order}, {2'd1, 8'd9});
        step(2'b11, 8'd20, 8'd21, 1'b0);
        chk("t5_count", 64'(count), 64'd3);
        chk("t5_err", 64'(order_err), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("t5_async_valid", 64'(out_valid), 64'd0);
        chk("t5_async_count", 64'(count), 64'd0);
        chk("t5_async_flags", {overflow, order_err}, 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // mixed traffic with irregular ready
        ord = 8'd40;
        for (int i = 0; i < 10; i++) begin
            case (vv[i])
                2'b11:   begin step(vv[i], ord, ord + 8'd1, (i % 3) != 0); ord = ord + 8'd2; end
                2'b10:   begin step(vv[i], 8'd0, ord, (i % 3) != 0); ord = ord + 8'd1; end
                2'b01:   begin step(vv[i], ord, 8'd0, (i % 3) != 0); ord = ord + 8'd1; end
                default: step(vv[i], 8'd0, 8'd0, (i % 3) != 0);
            endcase
        end
        repeat (10) step(2'b00, 8'd0, 8'd0, 1'b1);
        chk("t6_drained", 64'(count), 64'd0);

        @(negedge clk);
        done = 1'b1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
